matrix_row_reader: RTL

- Read-side initiator for the layered matrix storage.
- On a start command it walks a range of layers and, for each layer, rows 0..size-1. It drives the storage read port (layer/row index, is_read) and captures each returned row.
- Each captured row is presented on a valid/ready stream to the downstream compute datapath (forward-pass MAC array).

---
 rtl/matrix_row_reader_if.sv | 34 +++
 rtl/matrix_row_reader.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/matrix_row_reader_if.sv
// Storage read port plus downstream row stream for matrix_row_reader.
// The master side is the reader; the slave side is storage plus the compute datapath.
interface matrix_row_reader_if #(
  parameter int size      = 3,
  parameter int data_size = 16
);
  logic [31:0]               read_layer_index;
  logic [31:0]               read_row_index;
  logic                      is_read;
  logic [data_size*size-1:0] read_data;

  // Row stream: a row transfers on any edge where row_valid && row_ready;
  // once row_valid rises, row_data/row_layer/row_index/row_last hold until that edge.
  logic [data_size*size-1:0] row_data;
  logic                      row_valid;
  logic                      row_ready;
  logic [31:0]               row_layer;
  logic [31:0]               row_index;
  logic                      row_last;

  modport master (
    output read_layer_index, read_row_index, is_read,
    input  read_data,
    output row_data, row_valid, row_layer, row_index, row_last,
    input  row_ready
  );

  modport slave (
    input  read_layer_index, read_row_index, is_read,
    output read_data,
    input  row_data, row_valid, row_layer, row_index, row_last,
    output row_ready
  );
endinterface

// File: rtl/matrix_row_reader.sv
// Walks a layer range row by row, reading storage and streaming rows downstream.
// Optional MATRIX_ROW_READER_REVERSE_EN adds a reverse input for a downward layer walk.
module matrix_row_reader #(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int max_layer = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] start_layer_index,
  input  logic [31:0] layer_count,
`ifdef MATRIX_ROW_READER_REVERSE_EN
  input  logic        reverse,
`endif
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  dbg_state,
  matrix_row_reader_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [31:0]               cur_layer_q, cur_layer_d;
  logic [31:0]               cur_row_q, cur_row_d;
  logic [31:0]               remaining_q, remaining_d;
  logic [data_size*size-1:0] row_data_q, row_data_d;
  logic                      row_valid_q, row_valid_d;
  logic [31:0]               row_layer_q, row_layer_d;
  logic [31:0]               row_index_q, row_index_d;
  logic                      row_last_q, row_last_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      error_q, error_d;
  logic                      walk_down_q, walk_down_d;
  logic                      is_read;
  logic                      row_hs;
  logic                      fwd_reject;
  logic                      reject;
  logic                      start_down;

  // 33-bit sums so start_layer_index + layer_count cannot wrap into a legal range.
  assign fwd_reject = (layer_count == 32'd0) ||
                      (({1'b0, start_layer_index} + {1'b0, layer_count}) > 33'(max_layer));

`ifdef MATRIX_ROW_READER_REVERSE_EN
  logic rev_reject;
  assign rev_reject = (layer_count == 32'd0) ||
                      (start_layer_index >= 32'(max_layer)) ||
                      ({1'b0, layer_count} > ({1'b0, start_layer_index} + 33'd1));
  assign start_down = reverse;
  assign reject     = reverse ? rev_reject : fwd_reject;
`else
  assign start_down = 1'b0;
  assign reject     = fwd_reject;
`endif

  assign row_hs = row_valid_q && bus.row_ready;

  always_comb begin
    state_d     = state_q;
    cur_layer_d = cur_layer_q;
    cur_row_d   = cur_row_q;
    remaining_d = remaining_q;
    row_data_d  = row_data_q;
    row_valid_d = row_valid_q;
    row_layer_d = row_layer_q;
    row_index_d = row_index_q;
    row_last_d  = row_last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    walk_down_d = walk_down_q;
    is_read     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (reject) begin
            error_d = 1'b1;
          end else begin
            cur_layer_d = start_layer_index;
            cur_row_d   = 32'd0;
            remaining_d = 32'(layer_count * size);
            walk_down_d = start_down;
            busy_d      = 1'b1;
            state_d     = RUN;
          end
        end
      end

      RUN: begin
        // A new row is fetched whenever the output register is empty or draining this edge.
        is_read = !row_valid_q || bus.row_ready;
        if (is_read) begin
          row_data_d  = bus.read_data;
          row_valid_d = 1'b1;
          row_layer_d = cur_layer_q;
          row_index_d = cur_row_q;
          row_last_d  = (remaining_q == 32'd1);
          if (cur_row_q == 32'(size - 1)) begin
            cur_row_d   = 32'd0;
            cur_layer_d = walk_down_q ? (cur_layer_q - 32'd1) : (cur_layer_q + 32'd1);
          end else begin
            cur_row_d = cur_row_q + 32'd1;
          end
          remaining_d = remaining_q - 32'd1;
          if (remaining_q == 32'd1) begin
            state_d = DRAIN;
          end
        end else if (row_hs) begin
          row_valid_d = 1'b0;
        end
      end

      DRAIN: begin
        if (row_hs) begin
          row_valid_d = 1'b0;
          row_last_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_layer_q <= 32'd0;
      cur_row_q   <= 32'd0;
      remaining_q <= 32'd0;
      row_data_q  <= '0;
      row_valid_q <= 1'b0;
      row_layer_q <= 32'd0;
      row_index_q <= 32'd0;
      row_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      walk_down_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_layer_q <= cur_layer_d;
      cur_row_q   <= cur_row_d;
      remaining_q <= remaining_d;
      row_data_q  <= row_data_d;
      row_valid_q <= row_valid_d;
      row_layer_q <= row_layer_d;
      row_index_q <= row_index_d;
      row_last_q  <= row_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      walk_down_q <= walk_down_d;
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign error                = error_q;
  assign dbg_state            = state_q;
  assign bus.read_layer_index = cur_layer_q;
  assign bus.read_row_index   = cur_row_q;
  assign bus.is_read          = is_read;
  assign bus.row_data         = row_data_q;
  assign bus.row_valid        = row_valid_q;
  assign bus.row_layer        = row_layer_q;
  assign bus.row_index        = row_index_q;
  assign bus.row_last         = row_last_q;

endmodule
